// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: soft-clear FSM encoding
// and an elaboration-time log2 helper.
package regfile_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CLEARING = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;

  // Smallest r such that 2**r >= value; used to size address fields.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Soft-clear sequencer: walks an address counter over every register, one per cycle,
// then signals completion with a single-cycle pulse.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic          Clock,
  input  logic          Clear,
  input  logic          SoftClear,
  output logic          ClearBusy,
  output logic          ClearDone,
  output logic          clear_en,
  output logic [AW-1:0] clear_addr
);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (SoftClear) begin
          state_d = CLEARING;
          cnt_d   = '0;
        end
      end
      CLEARING: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ClearBusy  = (state_q == CLEARING);
  assign ClearDone  = (state_q == DONE);
  assign clear_en   = ClearBusy;
  assign clear_addr = cnt_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised multi-read-port register file with optional zero register, write-to-read
// bypass and a sequential soft-clear engine.
module regfile_param
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH    = 18,
  parameter  int unsigned DEPTH    = 16,
  parameter  int unsigned NUM_RD   = 2,
  parameter  bit          ZERO_REG = 1'b0,
  parameter  bit          BYPASS   = 1'b1,
  localparam int unsigned AW       = clog2(DEPTH)
) (
  input  logic                    Clock,
  input  logic                    Clear,
  input  logic [NUM_RD*AW-1:0]    ReadSelect,
  output logic [NUM_RD*WIDTH-1:0] ReadData,
  input  logic [AW-1:0]           WriteSelect,
  input  logic [WIDTH-1:0]        WriteData,
  input  logic                    WriteEnable,
  output logic                    WriteAccept,
  input  logic                    SoftClear,
  output logic                    ClearBusy,
  output logic                    ClearDone
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic             clear_en;
  logic [AW-1:0]    clear_addr;
  logic             write_zero;

  regfile_clear_seq #(
    .DEPTH(DEPTH)
  ) u_clear_seq (
    .Clock      (Clock),
    .Clear      (Clear),
    .SoftClear  (SoftClear),
    .ClearBusy  (ClearBusy),
    .ClearDone  (ClearDone),
    .clear_en   (clear_en),
    .clear_addr (clear_addr)
  );

  assign WriteAccept = WriteEnable & ~ClearBusy;
  assign write_zero  = ZERO_REG && (WriteSelect == '0);

  // Clear engine owns the write port while active; writes are already blocked then.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
    end else if (clear_en) begin
      regs_q[clear_addr] <= '0;
    end else if (WriteAccept && !write_zero) begin
      regs_q[WriteSelect] <= WriteData;
    end
  end

  for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
    logic [AW-1:0]    sel;
    logic             hit;
    logic [WIDTH-1:0] rdata;

    assign sel = ReadSelect[i*AW +: AW];
    // Bypass is held off during reset so every port reads 0 while Clear is low.
    assign hit = BYPASS && Clear && WriteAccept && (WriteSelect == sel) && !write_zero;

    always_comb begin
      rdata = regs_q[sel];
      if (ZERO_REG && (sel == '0)) begin
        rdata = '0;
      end else if (hit) begin
        rdata = WriteData;
      end
    end

    assign ReadData[i*WIDTH +: WIDTH] = rdata;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default, no-bypass, zero-register and wide/deep builds.
module tb_regfile_param;

  logic        Clock = 1'b0;
  logic        Clear;
  logic [7:0]  rsel;
  logic [3:0]  wsel;
  logic [17:0] wdata;
  logic        we, sc;

  logic [35:0] rd, rd_nb, rd_z;
  logic        wa, wa_nb, wa_z;
  logic        busy, busy_nb, busy_z;
  logic        done, done_nb, done_z;

  logic [19:0] w_rsel;
  logic [4:0]  w_wsel;
  logic [7:0]  w_wdata;
  logic        w_we, w_sc;
  logic [31:0] w_rd;
  logic        w_wa, w_busy, w_done;

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  regfile_param dut (
    .Clock(Clock), .Clear(Clear), .ReadSelect(rsel), .ReadData(rd), .WriteSelect(wsel),
    .WriteData(wdata), .WriteEnable(we), .WriteAccept(wa), .SoftClear(sc),
    .ClearBusy(busy), .ClearDone(done)
  );

  regfile_param #(.BYPASS(1'b0)) dut_nb (
    .Clock(Clock), .Clear(Clear), .ReadSelect(rsel), .ReadData(rd_nb), .WriteSelect(wsel),
    .WriteData(wdata), .WriteEnable(we), .WriteAccept(wa_nb), .SoftClear(sc),
    .ClearBusy(busy_nb), .ClearDone(done_nb)
  );

  regfile_param #(.ZERO_REG(1'b1)) dut_z (
    .Clock(Clock), .Clear(Clear), .ReadSelect(rsel), .ReadData(rd_z), .WriteSelect(wsel),
    .WriteData(wdata), .WriteEnable(we), .WriteAccept(wa_z), .SoftClear(sc),
    .ClearBusy(busy_z), .ClearDone(done_z)
  );

  regfile_param #(.WIDTH(8), .DEPTH(32), .NUM_RD(4)) dut_w (
    .Clock(Clock), .Clear(Clear), .ReadSelect(w_rsel), .ReadData(w_rd), .WriteSelect(w_wsel),
    .WriteData(w_wdata), .WriteEnable(w_we), .WriteAccept(w_wa), .SoftClear(w_sc),
    .ClearBusy(w_busy), .ClearDone(w_done)
  );

  typedef struct {
    logic        we;
    logic [3:0]  wsel;
    logic [17:0] wdata;
    logic [3:0]  rs0;
    logic [3:0]  rs1;
    logic [17:0] e0;
    logic [17:0] e1;
    logic [17:0] nb0;
    logic [17:0] z0;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Lands 1 time unit after a falling edge, well clear of the rising edge.
  task automatic step();
    @(negedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; sc = 1'b0; wsel = '0; wdata = '0;
    w_we = 1'b0; w_sc = 1'b0; w_wsel = '0; w_wdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int busy_cnt, done_cnt;

    vecs[0] = '{1'b1, 4'd5,  18'h2ABCD, 4'd5, 4'd0,  18'h2ABCD, 18'h00000, 18'h00000, 18'h2ABCD};
    vecs[1] = '{1'b1, 4'd15, 18'h3FFFF, 4'd5, 4'd15, 18'h2ABCD, 18'h3FFFF, 18'h2ABCD, 18'h2ABCD};
    vecs[2] = '{1'b0, 4'd0,  18'h00000, 4'd5, 4'd15, 18'h2ABCD, 18'h3FFFF, 18'h2ABCD, 18'h2ABCD};
    vecs[3] = '{1'b1, 4'd7,  18'h12345, 4'd7, 4'd5,  18'h12345, 18'h2ABCD, 18'h00000, 18'h12345};
    vecs[4] = '{1'b0, 4'd0,  18'h00000, 4'd7, 4'd7,  18'h12345, 18'h12345, 18'h12345, 18'h12345};
    vecs[5] = '{1'b1, 4'd5,  18'h00001, 4'd0, 4'd5,  18'h00000, 18'h00001, 18'h00000, 18'h00000};
    vecs[6] = '{1'b0, 4'd0,  18'h00000, 4'd5, 4'd15, 18'h00001, 18'h3FFFF, 18'h00001, 18'h00001};
    vecs[7] = '{1'b1, 4'd0,  18'h00FFF, 4'd0, 4'd0,  18'h00FFF, 18'h00FFF, 18'h00000, 18'h00000};
    vecs[8] = '{1'b0, 4'd0,  18'h00000, 4'd0, 4'd7,  18'h00FFF, 18'h12345, 18'h00FFF, 18'h00000};

    // Reset with busy-looking inputs.
    Clear = 1'b0;
    we = 1'b1; wsel = 4'd3; wdata = 18'h3FFFF; rsel = {4'd3, 4'd3}; sc = 1'b1;
    w_we = 1'b1; w_wsel = 5'd3; w_wdata = 8'hFF; w_rsel = {5'd3, 5'd3, 5'd3, 5'd3}; w_sc = 1'b1;
    #2;
    check("reset_rd", rd, 36'h0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_wide_rd", w_rd, 0);
    step();
    step();
    Clear = 1'b1;
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      rsel = {4'd0, 4'(i)};
      #1;
      check($sformatf("post_reset_r%0d", i), rd[17:0], 0);
    end
    check("post_reset_busy", busy, 0);

    for (int v = 0; v < 9; v++) begin
      step();
      we = vecs[v].we; wsel = vecs[v].wsel; wdata = vecs[v].wdata;
      rsel = {vecs[v].rs1, vecs[v].rs0};
      #1;
      check($sformatf("vec%0d_p0", v), rd[17:0], vecs[v].e0);
      check($sformatf("vec%0d_p1", v), rd[35:18], vecs[v].e1);
      check($sformatf("vec%0d_accept", v), wa, vecs[v].we);
      check($sformatf("vec%0d_nobyp_p0", v), rd_nb[17:0], vecs[v].nb0);
      check($sformatf("vec%0d_zero_p0", v), rd_z[17:0], vecs[v].z0);
    end

    // Soft clear on the 16-entry file.
    for (int i = 0; i < 16; i++) begin
      step();
      we = 1'b1; wsel = 4'(i); wdata = 18'(i + 1);
    end
    step();
    we = 1'b0; sc = 1'b1; rsel = {4'd15, 4'd0};
    #1;
    check("fill_r0", rd[17:0], 18'd1);
    check("fill_r15", rd[35:18], 18'd16);
    check("sc_request_busy", busy, 0);
    busy_cnt = 0; done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      sc = 1'b0;
      we = (n == 2); wsel = 4'd3; wdata = 18'h3AAAA;
      rsel = (n == 5) ? {4'd5, 4'd4} : {4'd15, 4'd3};
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        check("done_exclusive_busy", busy, 0);
      end
      if (n == 2) begin
        check("midclear_accept", wa, 0);
        check("midclear_nobypass_r3", rd[17:0], 18'd4);
      end
      if (n == 5) begin
        check("midclear_r4_cleared", rd[17:0], 0);
        check("midclear_r5_kept", rd[35:18], 18'd6);
      end
    end
    we = 1'b0;
    check("clear_busy_cycles", busy_cnt, 16);
    check("clear_done_pulses", done_cnt, 1);
    for (int i = 0; i < 16; i++) begin
      rsel = {4'(15 - i), 4'(i)};
      #1;
      check($sformatf("cleared_r%0d", i), {rd[35:18], rd[17:0]}, 0);
    end

    // Wide/deep build: write/read then a 32-cycle soft clear.
    step();
    w_we = 1'b1; w_wsel = 5'd5; w_wdata = 8'hAB;
    step();
    w_we = 1'b1; w_wsel = 5'd31; w_wdata = 8'hFF;
    step();
    w_we = 1'b0; w_rsel = {5'd31, 5'd5, 5'd0, 5'd0};
    #1;
    check("wide_p2_r5", w_rd[23:16], 8'hAB);
    check("wide_p3_r31", w_rd[31:24], 8'hFF);
    check("wide_p0_r0", w_rd[7:0], 0);
    w_sc = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int n = 0; n < 50; n++) begin
      step();
      w_sc = 1'b0;
      #1;
      if (w_busy) busy_cnt++;
      if (w_done) done_cnt++;
    end
    check("wide_busy_cycles", busy_cnt, 32);
    check("wide_done_pulses", done_cnt, 1);
    check("wide_cleared", w_rd, 0);

    // Reset asserted part-way through a clear.
    step();
    we = 1'b1; wsel = 4'd2; wdata = 18'h00111;
    step();
    we = 1'b0; rsel = {4'd0, 4'd2};
    #1;
    check("pre_abort_r2", rd[17:0], 18'h00111);
    sc = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step();
      sc = 1'b0;
      #1;
      check($sformatf("abort_busy%0d", n), busy, 1);
    end
    Clear = 1'b0;
    #1;
    check("abort_busy_low", busy, 0);
    check("abort_done_low", done, 0);
    check("abort_r2_zero", rd[17:0], 0);
    step();
    Clear = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    check("abort_no_busy", busy_cnt, 0);
    check("abort_no_done", done_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
